// File: rtl/mem_seg_pkg.sv
// mem_seg_pkg: shared FSM state type and active-low seven-segment patterns
package mem_seg_pkg;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_NEXT, S_COMMIT} state_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/seg_decoder.sv
// seg_decoder: registered hex nibble to active-low seven-segment lookup
import mem_seg_pkg::*;
module seg_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) seg <= SEG_LUT[0];
    else if (en) seg <= SEG_LUT[nib];
endmodule

// File: rtl/mem_seg_monitor.sv
// mem_seg_monitor: periodic memory scan committed atomically to 7-seg digits
// MEM_SEG_HEARTBEAT_EN: led blinks from a free-running counter instead of mirroring scan_err
import mem_seg_pkg::*;
module mem_seg_monitor #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_WORDS      = 3,
  parameter int BASE_ADDR      = 0,
  parameter int CLK_FREQ       = 10_000_000,
  parameter int REFRESH_HZ     = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    bus_busy,
  output logic                    rd_req,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    rd_valid,
  output logic [14*NUM_WORDS-1:0] seg,
  output logic                    scan_done,
  output logic                    scan_err,
  output logic                    led
);
  localparam int DIV = CLK_FREQ / REFRESH_HZ;
  localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int IW  = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  state_t state, nxt;
  logic [DW-1:0] div_cnt;
  logic [IW-1:0] idx;
  logic [TW-1:0] t_cnt;
  logic [NUM_WORDS-1:0][7:0] shadow;
  logic tick, last, timeout, commit;
  logic unused_mid;
  assign unused_mid = ^rd_data;
  assign tick    = div_cnt == DW'(DIV - 1);
  assign last    = idx == IW'(NUM_WORDS - 1);
  assign timeout = state == S_WAIT && !rd_valid && t_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign rd_addr = BASE + ADDR_WIDTH'(idx);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div_cnt <= '0;
    else div_cnt <= tick ? '0 : div_cnt + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = tick && enable ? S_REQ : S_IDLE;
      S_REQ:    nxt = !enable ? S_IDLE : bus_busy ? S_REQ : S_WAIT;
      S_WAIT:   nxt = rd_valid ? S_NEXT : timeout ? S_IDLE : S_WAIT;
      S_NEXT:   nxt = !enable ? S_IDLE : last ? S_COMMIT : S_REQ;
      default:  nxt = S_IDLE;
    endcase
  end
  always_comb begin
    rd_req = state == S_REQ && enable && !bus_busy;
    commit = state == S_COMMIT && enable;
  end
  // only the two displayed nibbles of each word are kept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx       <= '0;
      t_cnt     <= '0;
      shadow    <= '0;
      scan_done <= 1'b0;
      scan_err  <= 1'b0;
    end else begin
      idx       <= state == S_IDLE ? '0 : state == S_NEXT && !last ? idx + 1'b1 : idx;
      t_cnt     <= state == S_WAIT ? t_cnt + 1'b1 : '0;
      if (state == S_WAIT && rd_valid)
        shadow[idx] <= {rd_data[DATA_WIDTH-1 -: 4], rd_data[3:0]};
      scan_done <= commit;
      scan_err  <= timeout ? 1'b1 : commit ? 1'b0 : scan_err;
    end
  // decoder registers double as the committed display
  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
    seg_decoder u_lo (.clk(clk), .rst_n(rst_n), .en(commit), .nib(shadow[k][3:0]), .seg(seg[14*k +: 7]));
    seg_decoder u_hi (.clk(clk), .rst_n(rst_n), .en(commit), .nib(shadow[k][7:4]), .seg(seg[14*k+7 +: 7]));
  end
`ifdef MEM_SEG_HEARTBEAT_EN
  localparam int HALF = CLK_FREQ / 2;
  localparam int HW   = HALF > 1 ? $clog2(HALF) : 1;
  logic [HW-1:0] hb_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hb_cnt <= '0;
      led    <= 1'b0;
    end else if (hb_cnt == HW'(HALF - 1)) begin
      hb_cnt <= '0;
      led    <= ~led;
    end else hb_cnt <= hb_cnt + 1'b1;
`else
  assign led = scan_err;
`endif
endmodule

// File: doc/mem_seg_monitor.md
# mem_seg_monitor

Parametrised memory-to-seven-segment monitor for the DE10 board top. At a programmable refresh rate it scans NUM_WORDS consecutive words from on-chip memory through a request/valid read port, yielding to the programming controller whenever the bus is busy. It commits a complete snapshot atomically and drives two active-low seven-segment digits per word. It generalises the fixed three-word, direct-array-tap display to any depth, base address and data width.

## Interface
- ADDR_WIDTH, 10: memory address width.
- DATA_WIDTH, 32: memory word width; must be ≥ 8 and a multiple of 4.
- NUM_WORDS, 3: words scanned; produces 2*NUM_WORDS digits.
- BASE_ADDR, 0: address of word 0.
- CLK_FREQ, 10_000_000: clk frequency in Hz.
- REFRESH_HZ, 10: scan rate.
- TIMEOUT_CYCLES, 16: maximum wait for rd_valid.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  scanning allowed.
- bus_busy  in  1  memory owned by the programming controller; no new request is issued.
- rd_req  out  1  one-cycle read strobe.
- rd_addr  out  ADDR_WIDTH  read address.
- rd_data  in  DATA_WIDTH  read data, qualified by rd_valid.
- rd_valid  in  1  read data valid.
- seg  out  14*NUM_WORDS  digits; seg[7d+6:7d] is digit d, active-low, bit 0 = a … bit 6 = g.
- scan_done  out  1  one-cycle pulse on snapshot commit.
- scan_err  out  1  a timeout aborted the last scan.
- led  out  1  heartbeat (see Configuration).

## Operation
- Refresh divider counts 0..CLK_FREQ/REFRESH_HZ-1 and emits a one-cycle tick at wrap. It free-runs regardless of enable.
- FSM states: IDLE, REQ, WAIT, NEXT, COMMIT.
  - IDLE: on tick && enable → REQ, index ← 0.
  - REQ: if !bus_busy, assert rd_req and → WAIT. Otherwise stay in REQ with no request and no timeout.
  - WAIT: on rd_valid, shadow[index] ← rd_data and → NEXT. When the timeout counter reaches TIMEOUT_CYCLES-1 without rd_valid, set scan_err and → IDLE; the display is unchanged.
  - NEXT: if index == NUM_WORDS-1 → COMMIT; else index+1 and → REQ.
  - COMMIT: display ← shadow (all words in one cycle), pulse scan_done, clear scan_err, → IDLE.
- rd_addr = BASE_ADDR + index, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH). Held stable from REQ through WAIT.
- Digit mapping: digit 2k = display[k][3:0]; digit 2k+1 = display[k][DATA_WIDTH-1:DATA_WIDTH-4].
- Boundary conditions:
  - Ticks arriving outside IDLE are dropped, not queued.
  - enable low in REQ/NEXT/COMMIT → IDLE next edge with no commit. In WAIT, the FSM finishes or times out first, so no response is orphaned.
  - bus_busy rising during WAIT has no effect.
  - rd_valid outside WAIT is ignored.
  - Asynchronous reset mid-scan discards shadow and returns to IDLE.
- Reset values: rd_req 0, rd_addr BASE_ADDR, scan_done 0, scan_err 0, led 0, display and shadow 0. Every digit therefore shows "0" (7'b1000000).

## Timing
- rd_req is high for exactly one cycle per word. The earliest rd_valid is the cycle after rd_req.
- Minimum scan with no stalls and 1-cycle read latency: tick → scan_done = 3*NUM_WORDS+1 cycles after entering REQ.
- seg is a registered decode: it updates the cycle after COMMIT.
- scan_err asserts the cycle after timeout is detected and stays high until the next COMMIT.

## Configuration
- MEM_SEG_HEARTBEAT_EN defined: led toggles every CLK_FREQ/2 cycles via a free-running counter reset to 0.
- Not defined: the counter is removed and led is tied to scan_err.

## Structure
- Package mem_seg_pkg holds:
  - the FSM state enum;
  - the 16-entry active-low segment constant table;
  - the blank pattern 7'b1111111.
- Sub-module seg_decoder is instantiated once per digit (2*NUM_WORDS): a registered 4-bit → 7-bit lookup using the package table.

## Test plan
Bench parameters: CLK_FREQ=100, REFRESH_HZ=10, NUM_WORDS=3, BASE_ADDR=4, TIMEOUT_CYCLES=8.
- Reset release: all digits 7'b1000000, led 0, no rd_req before the first tick.
- Memory words 4/5/6 = 32'h1000000F, 32'hA0000003, 32'h70000000, 1-cycle latency → rd_addr 4, 5, 6, each with a one-cycle rd_req. After scan_done, digits = F, 1, 3, A, 0, 7.
- bus_busy high 20 cycles while in REQ → no rd_req during that window. The request issues on the first cycle bus_busy is low and the scan completes with correct data.
- Word 5 never answered → scan_err high 8 cycles after its rd_req, no scan_done, display keeps the previous snapshot. The next clean scan clears scan_err.
- enable dropped during REQ of word 1 → no commit. Rising enable resumes scanning at the next tick from index 0.
- BASE_ADDR=1022, ADDR_WIDTH=10 → addresses 1022, 1023, 0.
